// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller.
// Decodes a RISC-V style load/store, checks legality and alignment, issues a
// single memory request, and either converts the returned word into a
// sign/zero-extended load result or finishes on acknowledge/timeout.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, ir, addr, wdata  request: instruction, byte address, store data
//   busy, done, err, rdata  status: busy outside IDLE, done pulse, error, load data
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata   registered memory request
//   mem_rdata, mem_ack      memory response (ack is a single-cycle pulse)
module lsu_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, ACCESS, FIN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    // Load format and byte offset, kept for the conversion at acknowledge time.
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    // Only opcode and funct3 participate in decode.
    logic unused_ir;
    assign unused_ir = ^{ir[31:15], ir[11:7]};

    // ---------------- Decode of the incoming request ----------------
    logic [2:0]  f3;
    logic        is_load, is_store, legal, misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_data;

    assign f3 = ir[14:12];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        if (ir[6:0] == OP_LOAD)
            is_load = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                      (f3 == 3'b100) || (f3 == 3'b101);
        if (ir[6:0] == OP_STORE)
            is_store = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end

    assign legal      = is_load | is_store;
    // f3[1:0] encodes the access size for both loads and stores.
    assign misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                        ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        st_be   = 4'hF;
        st_data = wdata;
        if (is_store) begin
            case (f3[1:0])
                2'b00: begin
                    st_be   = 4'b0001 << addr[1:0];
                    st_data = {4{wdata[7:0]}};
                end
                2'b01: begin
                    st_be   = 4'b0011 << addr[1:0];
                    st_data = {2{wdata[15:0]}};
                end
                default: begin
                    st_be   = 4'hF;
                    st_data = wdata;
                end
            endcase
        end
    end

    // ---------------- Load result conversion ----------------
    logic [31:0] lane;
    logic [31:0] ld_val;

    assign lane = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_val = {24'd0, lane[7:0]};
            3'b101:  ld_val = {16'd0, lane[15:0]};
            default: ld_val = mem_rdata;
        endcase
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal && !misaligned) begin
                        state_d     = ACCESS;
                        cnt_d       = 8'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = st_be;
                        mem_wdata_d = st_data;
                        f3_d        = f3;
                        off_d       = addr[1:0];
                        err_d       = 1'b0;
                    end else begin
                        // Rejected without touching memory or rdata.
                        state_d = FIN;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Acknowledge wins over a timeout in the same cycle.
                if (mem_ack) begin
                    state_d   = FIN;
                    mem_req_d = 1'b0;
                    err_d     = 1'b0;
                    if (!mem_we_q)
                        rdata_d = ld_val;
                end else if (cnt_q == TIMEOUT) begin
                    state_d   = FIN;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed cases plus randomized load/store traffic
// checked against a behavioural model of the access rules.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] ir, addr, wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    // Model state: last completed load result and status.
    logic [31:0] rdata_m = 32'd0;
    logic        err_m   = 1'b0;

    lsu_ctrl #(.TIMEOUT(8'd4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] junk);
        logic [31:0] r;
        r        = junk;
        r[6:0]   = op;
        r[14:12] = f3;
        return r;
    endfunction

    // Load result from the word returned by memory, by access kind.
    function automatic logic [31:0] load_conv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (f3)
            3'd0:    return 32'($signed(v[7:0]));
            3'd1:    return 32'($signed(v[15:0]));
            3'd4:    return 32'(v[7:0]);
            3'd5:    return 32'(v[15:0]);
            default: return rd;
        endcase
    endfunction

    // One operation: start in the current IDLE cycle, ack after 'lat' ACCESS
    // cycles (lat > TO means never), optional noise on start/ack while busy.
    task automatic do_op(input logic [31:0] i_ir, input logic [31:0] i_addr,
                         input logic [31:0] i_wd, input logic [31:0] i_rd,
                         input int lat, input bit noise);
        logic [6:0]  op;
        logic [2:0]  f3;
        bit          ld, st, ok;
        int          sz, n;
        logic [3:0]  be_m;
        logic [31:0] wd_m;
        op = i_ir[6:0];
        f3 = i_ir[14:12];
        ld = (op == 7'b0000011) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        st = (op == 7'b0100011) && (f3 inside {3'd0, 3'd1, 3'd2});
        sz = 1 << f3[1:0];
        ok = (ld || st) && ((i_addr % sz) == 0);
        be_m = st ? 4'(((1 << sz) - 1) << (i_addr % 4)) : 4'hF;
        wd_m = (sz == 1) ? {4{i_wd[7:0]}} : (sz == 2) ? {2{i_wd[15:0]}} : i_wd;

        start = 1'b1; ir = i_ir; addr = i_addr; wdata = i_wd; mem_rdata = i_rd;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        if (!ok) begin
            err_m = 1'b1;
            chk("rej_mem_req", 32'(mem_req), 32'd0);
            chk("rej_done", 32'(done), 32'd1);
            chk("rej_err", 32'(err), 32'(err_m));
            chk("rej_rdata", rdata, rdata_m);
        end else begin
            n = (lat < TO) ? lat : TO;
            for (int k = 0; k <= n; k++) begin
                chk("acc_mem_req", 32'(mem_req), 32'd1);
                chk("acc_done", 32'(done), 32'd0);
                chk("acc_mem_addr", mem_addr, i_addr & 32'hFFFF_FFFC);
                chk("acc_mem_we", 32'(mem_we), 32'(st));
                chk("acc_mem_be", 32'(mem_be), 32'(be_m));
                if (st) chk("acc_mem_wdata", mem_wdata, wd_m);
                if (noise) begin
                    start = 1'($urandom); ir = $urandom; addr = $urandom; wdata = $urandom;
                end
                mem_ack = (k == lat);
                @(posedge clk); #1;
                mem_ack = 1'b0;
                start   = 1'b0;
            end
            if (lat <= TO) begin
                err_m = 1'b0;
                if (ld) rdata_m = load_conv(f3, i_addr, i_rd);
            end else begin
                err_m = 1'b1;
            end
            chk("fin_done", 32'(done), 32'd1);
            chk("fin_mem_req", 32'(mem_req), 32'd0);
            chk("fin_err", 32'(err), 32'(err_m));
            chk("fin_rdata", rdata, rdata_m);
        end
        if (noise) begin
            start = 1'b1; ir = mk_ir(7'b0000011, 3'd2, 32'd0); addr = 32'd0;
            mem_ack = 1'b1; mem_rdata = $urandom;
        end
        @(posedge clk); #1;
        start = 1'b0; mem_ack = 1'b0;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_err", 32'(err), 32'(err_m));
        chk("idle_rdata", rdata, rdata_m);
    endtask

    initial begin
        logic [31:0] r, a;
        logic [6:0]  op;
        rst_n = 1'b0; start = 1'b0; ir = 32'd0; addr = 32'd0; wdata = 32'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios.
        do_op(32'h0000_0003, 32'h1002, 32'd0, 32'h12B4_5678, 0, 0);        // LB
        chk("lb_rdata", rdata, 32'hFFFF_FFB4);
        do_op(32'h0000_5003, 32'h2002, 32'd0, 32'h8001_0000, 0, 0);        // LHU
        chk("lhu_rdata", rdata, 32'h0000_8001);
        do_op(32'h0000_1023, 32'h3002, 32'h0000_ABCD, 32'd0, 0, 0);        // SH
        do_op(32'h0000_2003, 32'h4001, 32'd0, 32'hDEAD_BEEF, 0, 0);        // LW misaligned
        do_op(32'h0000_2023, 32'h5000, 32'h1234_5678, 32'd0, 99, 1);       // SW timeout
        do_op(32'h0000_4003, 32'h6003, 32'd0, 32'h9ABC_DEF0, TO, 0);       // LBU ack at limit
        chk("lbu_ack_at_limit", rdata, 32'h0000_009A);
        do_op(32'h0000_3003, 32'h7000, 32'd0, 32'd0, 0, 0);                // LD-like illegal f3

        // Reset during ACCESS.
        start = 1'b1; ir = 32'h0000_2003; addr = 32'h8000;
        @(posedge clk); #1;
        start = 1'b0;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0; #1;
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_mid_done", 32'(done), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        rdata_m = 32'd0; err_m = 1'b0;
        @(posedge clk); #1;
        do_op(32'h0000_2003, 32'h9004, 32'd0, 32'hCAFE_F00D, 1, 0);        // LW after reset
        chk("lw_after_rst", rdata, 32'hCAFE_F00D);

        // Randomized traffic, back-to-back.
        for (int t = 0; t < 150; t++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    op = 7'b0000011;
                2:       op = 7'b0100011;
                default: op = 7'($urandom);
            endcase
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_op(mk_ir(op, 3'($urandom_range(0, 7)), r), a, $urandom, $urandom,
                  $urandom_range(0, 6), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
